// File: rtl/dsm_cic_decimator.sv
// CIC decimator for MASH/DSM modulator streams: ORDER integrators at the input rate,
// ORDER comb stages at the decimated rate, single-entry output register with overrun flag.
module dsm_cic_decimator #(
  parameter int IN_BW     = 4,
  parameter int ORDER     = 3,
  parameter int DECIM     = 16,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        aclk,
  input  logic                        rst,
  input  logic signed [IN_BW-1:0]     s_data,
  input  logic                        s_valid,
  output logic signed [OUT_WIDTH-1:0] m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        overrun
);

  localparam int ACC_W = IN_BW + ORDER * $clog2(DECIM);
  localparam int PH_W  = $clog2(DECIM);

  typedef logic [ACC_W-1:0] acc_t;

  acc_t                 x;
  acc_t                 isum    [ORDER];
  acc_t                 integ_q [ORDER];
  acc_t                 integ_d [ORDER];
  acc_t                 dec_q, dec_d;
  acc_t                 comb_in [ORDER];
  acc_t                 comb_q  [ORDER];
  acc_t                 comb_d  [ORDER];
  acc_t                 hist_q  [ORDER];
  acc_t                 hist_d  [ORDER];
  logic [ORDER:0]       stb_q, stb_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [OUT_WIDTH-1:0] m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;
  logic                 overrun_q, overrun_d;

  // Input mapping and same-cycle integrator chain.
  always_comb begin
    acc_t acc;
    if (IN_BW == 1) begin
      x = s_data[0] ? acc_t'(1) : '1;
    end else begin
      x = {{(ACC_W-IN_BW){s_data[IN_BW-1]}}, s_data};
    end
    acc = x;
    for (int k = 0; k < ORDER; k++) begin
      acc     = integ_q[k] + acc;
      isum[k] = acc;
    end
  end

  always_comb begin
    integ_d  = integ_q;
    phase_d  = phase_q;
    dec_d    = dec_q;
    stb_d    = '0;
    if (s_valid) begin
      integ_d = isum;
      if (phase_q == PH_W'(DECIM - 1)) begin
        phase_d  = '0;
        dec_d    = isum[ORDER-1];
        stb_d[0] = 1'b1;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end

    // Comb pipeline: stage k fires one cycle after stage k-1, history only moves on a strobe.
    comb_in[0] = dec_q;
    for (int k = 1; k < ORDER; k++) begin
      comb_in[k] = comb_q[k-1];
    end
    comb_d = comb_q;
    hist_d = hist_q;
    for (int k = 0; k < ORDER; k++) begin
      if (stb_q[k]) begin
        comb_d[k] = comb_in[k] - hist_q[k];
        hist_d[k] = comb_in[k];
      end
    end
    stb_d[ORDER:1] = stb_q[ORDER-1:0];
  end

  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    overrun_d = overrun_q;
    if (stb_q[ORDER]) begin
      m_data_d  = comb_q[ORDER-1][ACC_W-1 -: OUT_WIDTH];
      m_valid_d = 1'b1;
      if (m_valid_q && !m_ready) begin
        overrun_d = 1'b1;
      end
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      integ_q   <= '{default: '0};
      comb_q    <= '{default: '0};
      hist_q    <= '{default: '0};
      dec_q     <= '0;
      stb_q     <= '0;
      phase_q   <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      integ_q   <= integ_d;
      comb_q    <= comb_d;
      hist_q    <= hist_d;
      dec_q     <= dec_d;
      stb_q     <= stb_d;
      phase_q   <= phase_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Bench for dsm_cic_decimator: a default 4-bit instance and a 1-bit DSM instance, checked
// every cycle against a prefix-sum / finite-difference model plus directed literal values.
module tb_dsm_cic_decimator;

  localparam int ORD = 3;
  localparam int DEC = 16;

  logic               aclk = 1'b0;
  logic               rst;
  logic signed [3:0]  s_data;
  logic               s_data_b;
  logic               s_valid;
  logic               m_ready;
  logic signed [15:0] m_data;
  logic signed [12:0] m_data_b;
  logic               m_valid, m_valid_b;
  logic               overrun, overrun_b;

  dsm_cic_decimator #(.IN_BW(4), .ORDER(ORD), .DECIM(DEC), .OUT_WIDTH(16)) dut (
    .aclk(aclk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .overrun(overrun)
  );

  dsm_cic_decimator #(.IN_BW(1), .ORDER(ORD), .DECIM(DEC), .OUT_WIDTH(13)) dut_b (
    .aclk(aclk), .rst(rst), .s_data(s_data_b), .s_valid(s_valid),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready), .overrun(overrun_b)
  );

  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model state per instance (0: 4-bit, 1: 1-bit DSM).
  int     aw [2] = '{16, 13};
  int     ow [2] = '{16, 13};
  longint xs [2][$];
  longint vh [2][$];
  int     pdue [2][$];
  longint pval [2][$];
  int     phase [2];
  bit     mv [2];
  bit     ov [2];
  longint md [2];
  int     cyc = 0;
  bit     model_ok = 0;

  // Integrator output after all inputs so far: ORDER-fold running sum.
  function automatic longint integ_of(input longint q[$]);
    longint a[$];
    longint s;
    a = q;
    for (int r = 0; r < ORD; r++) begin
      s = 0;
      foreach (a[i]) begin
        s    += a[i];
        a[i]  = s;
      end
    end
    return a[a.size()-1];
  endfunction

  // ORDER-th backward difference of decimated samples, zero before the first one.
  function automatic longint comb_of(input longint v[$]);
    longint y = 0;
    longint c = 1;
    for (int j = 0; j <= ORD; j++) begin
      if (v.size() > j) y += ((j % 2) ? -c : c) * v[v.size()-1-j];
      c = c * (ORD - j) / (j + 1);
    end
    return y;
  endfunction

  function automatic longint trunc_pat(input longint y, input int a, input int o);
    return (y & ((longint'(1) << a) - 1)) >> (a - o);
  endfunction

  always @(posedge aclk) begin
    cyc++;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        xs[u].delete(); vh[u].delete(); pdue[u].delete(); pval[u].delete();
        phase[u] = 0; mv[u] = 0; ov[u] = 0; md[u] = 0;
      end else begin
        if (pdue[u].size() > 0 && pdue[u][0] == cyc) begin
          if (mv[u] && !m_ready) ov[u] = 1;
          mv[u] = 1;
          md[u] = pval[u].pop_front();
          void'(pdue[u].pop_front());
        end else if (mv[u] && m_ready) begin
          mv[u] = 0;
        end
        if (s_valid) begin
          xs[u].push_back(u == 0 ? longint'(s_data) : (s_data_b ? 64'sd1 : -64'sd1));
          phase[u]++;
          if (phase[u] == DEC) begin
            phase[u] = 0;
            vh[u].push_back(integ_of(xs[u]));
            pdue[u].push_back(cyc + ORD + 1);
            pval[u].push_back(trunc_pat(comb_of(vh[u]), aw[u], ow[u]));
          end
        end
      end
    end
    if (rst) model_ok = 1;
  end

  always @(negedge aclk) begin
    longint pat;
    if (model_ok) begin
      for (int u = 0; u < 2; u++) begin
        pat = 0;
        if (u == 0) pat[15:0] = m_data;
        else pat[12:0] = m_data_b;
        check($sformatf("m_valid[%0d]", u), longint'(u == 0 ? m_valid : m_valid_b),
              longint'(mv[u]));
        check($sformatf("overrun[%0d]", u), longint'(u == 0 ? overrun : overrun_b),
              longint'(ov[u]));
        check($sformatf("m_data[%0d]", u), pat, md[u]);
      end
    end
  end

  // Wait for the next output pulse; c = cycles waited, or -1 on timeout.
  task automatic wait_out(input int maxc, input bit tog, output int c, output longint d,
                          output longint db);
    bit found = 0;
    int n = 0;
    d  = 0;
    db = 0;
    while (!found && n < maxc) begin
      @(negedge aclk);
      n++;
      if (tog) s_valid = ~s_valid;
      if (m_valid) begin
        found = 1;
        d     = longint'(m_data);
        db    = 0;
        db[12:0] = m_data_b;
      end
    end
    c = found ? n : -1;
  endtask

  task automatic ticks(input int n, input bit tog);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      if (tog) s_valid = ~s_valid;
    end
  endtask

  initial begin
    int     c;
    longint d, db, last, lastb;
    int     exp_seq [4] = '{816, 3536, 4096, 4096};
    int     exp_lat [4] = '{20, 16, 16, 16};

    rst = 1; s_valid = 0; s_data = 4'sd1; s_data_b = 1; m_ready = 1;
    ticks(2, 0);
    check("rst_m_valid", longint'(m_valid), 0);
    check("rst_m_data", longint'(m_data), 0);
    check("rst_overrun", longint'(overrun), 0);

    // Constant +1 on both instances (all-ones stream for the DSM one).
    rst = 0; s_valid = 1;
    for (int k = 0; k < 4; k++) begin
      wait_out(40, 0, c, d, db);
      check($sformatf("t1_lat%0d", k), c, exp_lat[k]);
      check($sformatf("t1_val%0d", k), d, exp_seq[k]);
      check($sformatf("t1_dsm%0d", k), db, exp_seq[k]);
      if (k == 0) check("model_816", md[0], 816);
    end

    // Steady +7 then steady -8; DSM instance sees an alternating bitstream.
    s_data = 4'sd7;
    last = 0; lastb = -1;
    for (int i = 0; i < 320; i++) begin
      if (i == 160) begin
        check("t2_pos", last, 28672);
        check("model_pos", longint'(signed'(md[0][15:0])), 28672);
        s_data = -4'sd8;
      end
      @(negedge aclk);
      s_data_b = ~s_data_b;
      if (m_valid) last = longint'(m_data);
      if (m_valid_b) begin
        lastb = 0;
        lastb[12:0] = m_data_b;
      end
    end
    check("t2_neg", last, -32768);
    check("t2_dsm_alt", lastb, 0);

    // Hold m_ready low across two loads.
    s_data = 4'sd1; s_data_b = 1;
    wait_out(40, 0, c, d, db);
    check("t3_sync", longint'(c >= 0), 1);
    m_ready = 0;
    ticks(15, 0);
    check("t3_hold_valid", longint'(m_valid), 1);
    check("t3_no_ovr_yet", longint'(overrun), 0);
    ticks(5, 0);
    check("t3_ovr_valid", longint'(m_valid), 1);
    check("t3_ovr", longint'(overrun), 1);
    m_ready = 1;
    ticks(1, 0);
    check("t3_drained", longint'(m_valid), 0);
    check("t3_ovr_sticky", longint'(overrun), 1);

    // Reset, then 50% input duty: same values at twice the spacing.
    rst = 1;
    ticks(1, 0);
    check("t4_rst_ovr", longint'(overrun), 0);
    rst = 0; s_valid = 1;
    for (int k = 0; k < 3; k++) begin
      wait_out(80, 1, c, d, db);
      check($sformatf("t4_lat%0d", k), c, k == 0 ? 35 : 32);
      check($sformatf("t4_val%0d", k), d, exp_seq[k]);
    end

    // Reset while a decimated sample is inside the comb pipeline.
    ticks(29, 1);
    rst = 1;
    ticks(1, 0);
    check("t5_rst_valid", longint'(m_valid), 0);
    check("t5_rst_data", longint'(m_data), 0);
    check("t5_rst_ovr", longint'(overrun), 0);
    rst = 0; s_valid = 1;
    wait_out(40, 0, c, d, db);
    check("t5_lat", c, 20);
    check("t5_val", d, 816);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule

// File: doc/dsm_cic_decimator.md
DSM_CIC_DECIMATOR -- requirements
Module: dsm_cic_decimator

Interface
REQ-001 SHALL provide parameter IN_BW, default 4, signed width of the MASH/DSM sample input; IN_BW=1 selects 1-bit DSM mode.
REQ-002 SHALL provide parameter ORDER, default 3, number of integrator and comb stages (1..5).
REQ-003 SHALL provide parameter DECIM, default 16, decimation ratio; power of two, DECIM >= ORDER+2.
REQ-004 SHALL provide parameter OUT_WIDTH, default 16, signed output width; OUT_WIDTH <= ACC_W.
REQ-005 SHALL define ACC_W = IN_BW + ORDER*$clog2(DECIM) (16 at defaults) as the width of every integrator and comb register.
REQ-006 aclk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset, sampled on rising aclk.
REQ-008 s_data  input  IN_BW  signed modulator sample (MASH output word, or DSM bit when IN_BW=1).
REQ-009 s_valid  input  1  s_data is accepted on every edge where s_valid=1; no backpressure.
REQ-010 m_data  output  OUT_WIDTH  signed decimated sample.
REQ-011 m_valid  output  1  m_data holds an unconsumed sample.
REQ-012 m_ready  input  1  downstream accepts; transfer on edge with m_valid=1 and m_ready=1.
REQ-013 overrun  output  1  sticky flag: an unconsumed sample was overwritten.

Function
REQ-014 SHALL, when IN_BW=1, map s_data 0 -> -1 and 1 -> +1 before integration; otherwise sign-extend s_data to ACC_W.
REQ-015 SHALL, on each accepted input, update integrators as a same-cycle chain: I1 <= I1+x, Ik <= Ik + (new Ik-1) for k=2..ORDER.
REQ-016 SHALL let all integrator and comb arithmetic wrap modulo 2^ACC_W (two's complement, no saturation).
REQ-017 SHALL keep a phase counter 0..DECIM-1 incremented per accepted input; on the input accepted at phase DECIM-1 the counter wraps to 0 and the new value of I_ORDER is captured as decimated sample.
REQ-018 SHALL hold integrators and phase counter unchanged on edges with s_valid=0.
REQ-019 SHALL run ORDER comb stages at the decimated rate, each Ck = in - in_prev (differential delay 1), one registered stage per aclk cycle, with zero initial history.
REQ-020 SHALL set m_data = comb output bits [ACC_W-1 : ACC_W-OUT_WIDTH] (arithmetic truncation).
REQ-021 SHALL assert m_valid with new m_data exactly ORDER+1 cycles after the edge that captured the decimated sample (4 cycles at defaults).
REQ-022 SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0, except on overwrite.
REQ-023 SHALL clear m_valid on the edge with m_valid=1, m_ready=1 when no new sample loads that edge.
REQ-024 SHALL, when a new sample loads on the same edge as a completed transfer, keep m_valid=1 with new m_data and leave overrun unchanged.
REQ-025 SHALL, when a new sample loads while m_valid=1 and m_ready=0, overwrite m_data, keep m_valid=1, and set overrun=1.
REQ-026 SHALL clear overrun only by rst.
REQ-027 SHALL ignore m_ready while m_valid=0.

Reset
REQ-028 SHALL, on any edge with rst=1, clear integrators, comb state and history, pipeline strobes, phase counter, m_data=0, m_valid=0, overrun=0, regardless of operation in progress.
REQ-029 SHALL discard in-flight comb samples on mid-operation reset; first post-reset output equals that of a fresh start.
REQ-030 SHALL accept input on the first edge after rst deasserts.

Verification
REQ-031 Defaults, m_ready=1, s_valid=1, s_data=+1 constant from reset -> outputs 816, 3536, 4096, then 4096 every 16 cycles; first m_valid 4 cycles after 16th input edge.
REQ-032 Defaults, s_data=+7 steady, then -8 steady -> settled outputs 28672 and -32768, no wrap artefacts across the transition settle.
REQ-033 IN_BW=1, alternating 1/0 bitstream -> settled output 0; all-ones stream -> settled 4096.
REQ-034 m_ready=0 across two decimation periods -> second sample overwrites first, overrun=1, m_valid=1; then m_ready=1 -> one transfer, m_valid=0, overrun stays 1.
REQ-035 s_valid toggling 50% with constant +1 -> same value sequence as REQ-031 at 32-cycle spacing; rst pulse mid-period -> all outputs 0, next sequence restarts at 816.
